bp_l15_decoder: RTL and testbench

Request-side transducer between the BlackParrot memory command channels and the OpenPiton L1.5 request interface. It accepts one read or write command from BP, registers it, and presents it as an L1.5 transducer request. It holds that request until the L1.5 acknowledges it, then blocks new commands until the L1.5 returns the matching response. Its address, payload and size outputs, together with the acknowledge pulse, feed the downstream L1.5→BP encoder, which captures request context at the acknowledge.

---
 rtl/bp_l15_decoder_if.sv | 56 +++++
 rtl/bp_l15_decoder.sv | 146 ++++++++++++++
 tb/tb_bp_l15_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_l15_decoder_if.sv
// Bundle of the BlackParrot command channels and the L1.5 request/response handshake.
// The slave modport is the decoder's view; the master modport is the environment's view.
interface bp_l15_decoder_if #(
    parameter int paddr_width_p       = 40,
    parameter int mem_payload_width_p = 10
);
    logic                           mem_cmd_v_i;
    logic                           mem_cmd_ready_o;
    logic [paddr_width_p-1:0]       mem_cmd_addr_i;
    logic [mem_payload_width_p-1:0] mem_cmd_payload_i;
    logic                           mem_cmd_nc_i;
    logic [1:0]                     mem_cmd_size_i;

    logic                           mem_data_cmd_v_i;
    logic                           mem_data_cmd_ready_o;
    logic [paddr_width_p-1:0]       mem_data_cmd_addr_i;
    logic [mem_payload_width_p-1:0] mem_data_cmd_payload_i;
    logic [1:0]                     mem_data_cmd_size_i;
    logic [63:0]                    mem_data_cmd_data_i;

    logic                           transducer_l15_val;
    logic [4:0]                     transducer_l15_rqtype;
    logic                           transducer_l15_nc;
    logic [2:0]                     transducer_l15_size;
    logic [paddr_width_p-1:0]       transducer_l15_address;
    logic [63:0]                    transducer_l15_data;
    logic                           l15_transducer_ack;
    logic                           l15_transducer_val;

    logic                           transducer_l15_req_ack;
    logic [mem_payload_width_p-1:0] mem_payload_o;
    logic [1:0]                     nc_size_o;
    logic                           protocol_error_o;

    modport slave (
        input  mem_cmd_v_i, mem_cmd_addr_i, mem_cmd_payload_i, mem_cmd_nc_i, mem_cmd_size_i,
        input  mem_data_cmd_v_i, mem_data_cmd_addr_i, mem_data_cmd_payload_i,
        input  mem_data_cmd_size_i, mem_data_cmd_data_i,
        input  l15_transducer_ack, l15_transducer_val,
        output mem_cmd_ready_o, mem_data_cmd_ready_o,
        output transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
        output transducer_l15_size, transducer_l15_address, transducer_l15_data,
        output transducer_l15_req_ack, mem_payload_o, nc_size_o, protocol_error_o
    );

    modport master (
        output mem_cmd_v_i, mem_cmd_addr_i, mem_cmd_payload_i, mem_cmd_nc_i, mem_cmd_size_i,
        output mem_data_cmd_v_i, mem_data_cmd_addr_i, mem_data_cmd_payload_i,
        output mem_data_cmd_size_i, mem_data_cmd_data_i,
        output l15_transducer_ack, l15_transducer_val,
        input  mem_cmd_ready_o, mem_data_cmd_ready_o,
        input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
        input  transducer_l15_size, transducer_l15_address, transducer_l15_data,
        input  transducer_l15_req_ack, mem_payload_o, nc_size_o, protocol_error_o
    );
endinterface

// File: rtl/bp_l15_decoder.sv
// Turns one BlackParrot read/write command into an L1.5 transducer request and
// blocks further commands until the L1.5 response for it has come back.
module bp_l15_decoder #(
    parameter int paddr_width_p       = 40,
    parameter int mem_payload_width_p = 10
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    bp_l15_decoder_if.slave bus
);
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_REQ    = 2'd1;
    localparam logic [1:0] STATE_WAIT   = 2'd2;
    localparam logic [4:0] RQTYPE_LOAD  = 5'b00000;
    localparam logic [4:0] RQTYPE_STORE = 5'b00001;

    logic [1:0]                     state_reg, state_next;
    logic [paddr_width_p-1:0]       addr_reg, addr_next;
    logic [mem_payload_width_p-1:0] payload_reg, payload_next;
    logic [1:0]                     nc_size_reg, nc_size_next;
    logic [2:0]                     pcx_size_reg, pcx_size_next;
    logic                           store_reg, store_next;
    logic                           nc_reg, nc_next;
    logic [63:0]                    data_reg, data_next;
    logic                           error_reg, error_next;

    logic        idle;
    logic        rd_fire;
    logic        wr_fire;
    logic        wr_aligned;
    logic [63:0] wr_data_rep;

    // Readies are gated by the reset input so they are low for the whole reset window.
    assign idle                     = reset_n_i & (state_reg == STATE_IDLE);
    assign bus.mem_data_cmd_ready_o = idle;
    assign bus.mem_cmd_ready_o      = idle & ~bus.mem_data_cmd_v_i;
    assign wr_fire                  = bus.mem_data_cmd_v_i & bus.mem_data_cmd_ready_o;
    assign rd_fire                  = bus.mem_cmd_v_i & bus.mem_cmd_ready_o;

    // Each store byte lane takes the source byte that repeats with the access width.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rep
        localparam int LO2 = (gi % 2) * 8;
        localparam int LO4 = (gi % 4) * 8;
        assign wr_data_rep[gi*8 +: 8] =
            (bus.mem_data_cmd_size_i == 2'd0) ? bus.mem_data_cmd_data_i[7:0] :
            (bus.mem_data_cmd_size_i == 2'd1) ? bus.mem_data_cmd_data_i[LO2 +: 8] :
            (bus.mem_data_cmd_size_i == 2'd2) ? bus.mem_data_cmd_data_i[LO4 +: 8] :
                                                bus.mem_data_cmd_data_i[gi*8 +: 8];
    end

    always_comb begin
        case (bus.mem_data_cmd_size_i)
            2'd0:    wr_aligned = 1'b1;
            2'd1:    wr_aligned = (bus.mem_data_cmd_addr_i[0] == 1'b0);
            2'd2:    wr_aligned = (bus.mem_data_cmd_addr_i[1:0] == 2'b00);
            default: wr_aligned = (bus.mem_data_cmd_addr_i[2:0] == 3'b000);
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        payload_next  = payload_reg;
        nc_size_next  = nc_size_reg;
        pcx_size_next = pcx_size_reg;
        store_next    = store_reg;
        nc_next       = nc_reg;
        data_next     = data_reg;
        error_next    = error_reg;
        case (state_reg)
            STATE_IDLE: begin
                if (wr_fire) begin
                    // A misaligned store is swallowed: flag it and stay idle.
                    if (wr_aligned) begin
                        addr_next     = bus.mem_data_cmd_addr_i;
                        payload_next  = bus.mem_data_cmd_payload_i;
                        nc_size_next  = bus.mem_data_cmd_size_i;
                        pcx_size_next = {1'b0, bus.mem_data_cmd_size_i};
                        store_next    = 1'b1;
                        nc_next       = 1'b1;
                        data_next     = wr_data_rep;
                        state_next    = STATE_REQ;
                    end else begin
                        error_next = 1'b1;
                    end
                end else if (rd_fire) begin
                    addr_next     = bus.mem_cmd_nc_i ? bus.mem_cmd_addr_i
                                                     : {bus.mem_cmd_addr_i[paddr_width_p-1:4], 4'b0000};
                    payload_next  = bus.mem_cmd_payload_i;
                    nc_size_next  = bus.mem_cmd_size_i;
                    pcx_size_next = bus.mem_cmd_nc_i ? {1'b0, bus.mem_cmd_size_i} : 3'b111;
                    store_next    = 1'b0;
                    nc_next       = bus.mem_cmd_nc_i;
                    data_next     = 64'd0;
                    state_next    = STATE_REQ;
                end
            end
            STATE_REQ: begin
                if (bus.l15_transducer_ack) begin
                    state_next = STATE_WAIT;
                end
            end
            STATE_WAIT: begin
                if (bus.l15_transducer_val) begin
                    state_next = STATE_IDLE;
                end
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= STATE_IDLE;
            addr_reg     <= '0;
            payload_reg  <= '0;
            nc_size_reg  <= '0;
            pcx_size_reg <= '0;
            store_reg    <= 1'b0;
            nc_reg       <= 1'b0;
            data_reg     <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            payload_reg  <= payload_next;
            nc_size_reg  <= nc_size_next;
            pcx_size_reg <= pcx_size_next;
            store_reg    <= store_next;
            nc_reg       <= nc_next;
            data_reg     <= data_next;
            error_reg    <= error_next;
        end
    end

    assign bus.transducer_l15_val     = (state_reg == STATE_REQ);
    assign bus.transducer_l15_rqtype  = store_reg ? RQTYPE_STORE : RQTYPE_LOAD;
    assign bus.transducer_l15_nc      = nc_reg;
    assign bus.transducer_l15_size    = pcx_size_reg;
    assign bus.transducer_l15_address = addr_reg;
    assign bus.transducer_l15_data    = data_reg;
    assign bus.transducer_l15_req_ack = bus.transducer_l15_val & bus.l15_transducer_ack;
    assign bus.mem_payload_o          = payload_reg;
    assign bus.nc_size_o              = nc_size_reg;
    assign bus.protocol_error_o       = error_reg;
endmodule

// File: tb/tb_bp_l15_decoder.sv
// Scoreboard bench for bp_l15_decoder: directed scenarios plus randomized commands,
// with expected L1.5 requests computed from the command-to-request mapping rules.
`timescale 1ns/1ps
module tb_bp_l15_decoder;
    localparam int AW = 40;
    localparam int PW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bp_l15_decoder_if #(.paddr_width_p(AW), .mem_payload_width_p(PW)) bus ();

    bp_l15_decoder #(.paddr_width_p(AW), .mem_payload_width_p(PW)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic [4:0]  rqtype;
        logic        nc;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [63:0] data;
        logic [9:0]  payload;
        logic [1:0]  nc_size;
    } req_t;

    req_t sb_q[$];
    req_t cur_exp;
    int   errors = 0;
    int   checks = 0;
    int   txn_count = 0;
    logic exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference mapping from a BP command to the L1.5 request it should become.
    function automatic req_t model(input bit is_wr, input logic [39:0] a, input logic [9:0] p,
                                   input logic [1:0] sz, input bit nc, input logic [63:0] d);
        req_t r;
        int nbytes;
        nbytes    = 1 << sz;
        r.payload = p;
        r.nc_size = sz;
        r.data    = '0;
        if (is_wr) begin
            r.rqtype = 5'd1;
            r.nc     = 1'b1;
            r.size   = {1'b0, sz};
            r.addr   = a;
            for (int b = 0; b < 8; b++) r.data[b*8 +: 8] = d[(b % nbytes)*8 +: 8];
        end else begin
            r.rqtype = 5'd0;
            r.nc     = nc;
            r.size   = nc ? {1'b0, sz} : 3'd7;
            r.addr   = nc ? a : (a / 40'd16) * 40'd16;
        end
        return r;
    endfunction

    function automatic bit aligned(input logic [39:0] a, input logic [1:0] sz);
        int n;
        n = 1 << sz;
        return (int'(a[3:0]) % n) == 0;
    endfunction

    // Monitor: every accepted request is popped from the scoreboard and compared.
    always @(negedge clk) begin
        req_t e;
        if (reset_n && bus.transducer_l15_req_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: req_ack with empty scoreboard, required none");
            end else begin
                e = sb_q.pop_front();
                txn_count++;
                check("sb_rqtype",  64'(bus.transducer_l15_rqtype),  64'(e.rqtype));
                check("sb_nc",      64'(bus.transducer_l15_nc),      64'(e.nc));
                check("sb_size",    64'(bus.transducer_l15_size),    64'(e.size));
                check("sb_address", 64'(bus.transducer_l15_address), 64'(e.addr));
                check("sb_data",    bus.transducer_l15_data,         e.data);
                check("sb_payload", 64'(bus.mem_payload_o),          64'(e.payload));
                check("sb_nc_size", 64'(bus.nc_size_o),              64'(e.nc_size));
                $display("txn %0d: rqtype=%0d nc=%0d size=%0d addr=0x%0h data=0x%0h payload=0x%0h",
                         txn_count, bus.transducer_l15_rqtype, bus.transducer_l15_nc,
                         bus.transducer_l15_size, bus.transducer_l15_address,
                         bus.transducer_l15_data, bus.mem_payload_o);
            end
        end
    end

    task automatic check_req_hold();
        check("req_val",     64'(bus.transducer_l15_val),     64'(1'b1));
        check("req_rqtype",  64'(bus.transducer_l15_rqtype),  64'(cur_exp.rqtype));
        check("req_nc",      64'(bus.transducer_l15_nc),      64'(cur_exp.nc));
        check("req_size",    64'(bus.transducer_l15_size),    64'(cur_exp.size));
        check("req_address", 64'(bus.transducer_l15_address), 64'(cur_exp.addr));
        check("req_data",    bus.transducer_l15_data,         cur_exp.data);
        check("req_busy",    64'(bus.mem_data_cmd_ready_o),   64'(1'b0));
    endtask

    // Drive one command until it is accepted; returns ok=1 when an L1.5 request is expected.
    task automatic issue(input bit is_wr, input logic [39:0] a, input logic [9:0] p,
                         input logic [1:0] sz, input bit nc, input logic [63:0] d, output bit ok);
        bit fired;
        fired = 1'b0;
        ok    = 1'b0;
        if (is_wr) begin
            bus.mem_data_cmd_v_i       = 1'b1;
            bus.mem_data_cmd_addr_i    = a;
            bus.mem_data_cmd_payload_i = p;
            bus.mem_data_cmd_size_i    = sz;
            bus.mem_data_cmd_data_i    = d;
        end else begin
            bus.mem_cmd_v_i       = 1'b1;
            bus.mem_cmd_addr_i    = a;
            bus.mem_cmd_payload_i = p;
            bus.mem_cmd_size_i    = sz;
            bus.mem_cmd_nc_i      = nc;
        end
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clk);
            if (is_wr ? bus.mem_data_cmd_ready_o : bus.mem_cmd_ready_o) fired = 1'b1;
            @(posedge clk); #1;
        end
        bus.mem_data_cmd_v_i = 1'b0;
        bus.mem_cmd_v_i      = 1'b0;
        if (!fired) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: ready stayed 0, required 1 within 50 cycles");
        end else if (is_wr && !aligned(a, sz)) begin
            exp_err = 1'b1;
            @(negedge clk);
            check("illegal_err",   64'(bus.protocol_error_o),     64'(exp_err));
            check("illegal_noval", 64'(bus.transducer_l15_val),   64'(1'b0));
            check("illegal_wrdy",  64'(bus.mem_data_cmd_ready_o), 64'(1'b1));
            check("illegal_rrdy",  64'(bus.mem_cmd_ready_o),      64'(1'b1));
            $display("txn illegal write addr=0x%0h size=%0d dropped", a, sz);
            @(posedge clk); #1;
        end else begin
            cur_exp = model(is_wr, a, p, sz, nc, d);
            sb_q.push_back(cur_exp);
            ok = 1'b1;
        end
    endtask

    // Play the L1.5 side: ack after ack_dly REQ cycles, respond resp_dly cycles after the ack cycle+1.
    task automatic l15_complete(input int ack_dly, input int resp_dly, input bit spurious);
        for (int i = 0; i < ack_dly; i++) begin
            if (spurious && i == 1) bus.l15_transducer_val = 1'b1;
            @(negedge clk);
            check_req_hold();
            check("req_ack_early", 64'(bus.transducer_l15_req_ack), 64'(1'b0));
            @(posedge clk); #1;
            bus.l15_transducer_val = 1'b0;
        end
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        check_req_hold();
        check("req_ack_pulse", 64'(bus.transducer_l15_req_ack), 64'(1'b1));
        @(posedge clk); #1;
        bus.l15_transducer_ack = 1'b0;
        for (int i = 0; i < resp_dly; i++) begin
            @(negedge clk);
            check("wait_val",   64'(bus.transducer_l15_val),   64'(1'b0));
            check("wait_ready", 64'(bus.mem_data_cmd_ready_o), 64'(1'b0));
            @(posedge clk); #1;
        end
        bus.l15_transducer_val = 1'b1;
        @(negedge clk);
        check("resp_ready_low", 64'(bus.mem_data_cmd_ready_o), 64'(1'b0));
        @(posedge clk); #1;
        bus.l15_transducer_val = 1'b0;
        @(negedge clk);
        check("done_wrdy", 64'(bus.mem_data_cmd_ready_o), 64'(1'b1));
        check("done_rrdy", 64'(bus.mem_cmd_ready_o),      64'(!bus.mem_data_cmd_v_i));
        check("done_err",  64'(bus.protocol_error_o),     64'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit is_wr;
        bit nc;
        logic [1:0]  sz;
        logic [39:0] a;
        logic [63:0] d;
        logic [9:0]  p;
        int n;

        bus.mem_cmd_v_i = 1'b0;            bus.mem_cmd_addr_i = '0;
        bus.mem_cmd_payload_i = '0;        bus.mem_cmd_nc_i = 1'b0;
        bus.mem_cmd_size_i = '0;           bus.mem_data_cmd_v_i = 1'b0;
        bus.mem_data_cmd_addr_i = '0;      bus.mem_data_cmd_payload_i = '0;
        bus.mem_data_cmd_size_i = '0;      bus.mem_data_cmd_data_i = '0;
        bus.l15_transducer_ack = 1'b0;     bus.l15_transducer_val = 1'b0;

        // Reset state
        #2;
        check("rst_val",     64'(bus.transducer_l15_val),     64'(1'b0));
        check("rst_wrdy",    64'(bus.mem_data_cmd_ready_o),   64'(1'b0));
        check("rst_rrdy",    64'(bus.mem_cmd_ready_o),        64'(1'b0));
        check("rst_req_ack", 64'(bus.transducer_l15_req_ack), 64'(1'b0));
        check("rst_err",     64'(bus.protocol_error_o),       64'(1'b0));
        check("rst_addr",    64'(bus.transducer_l15_address), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_wrdy", 64'(bus.mem_data_cmd_ready_o), 64'(1'b1));
        check("post_rst_rrdy", 64'(bus.mem_cmd_ready_o),      64'(1'b1));

        // Cached read: line-aligned address, 16B size
        issue(1'b0, 40'h80001234, 10'h2A, 2'd3, 1'b0, 64'd0, ok);
        if (ok) l15_complete(2, 2, 1'b0);

        // Non-cacheable 2B store with replicated data
        issue(1'b1, 40'h80000002, 10'h11, 2'd1, 1'b1, 64'hBEEF, ok);
        if (ok) l15_complete(1, 3, 1'b0);

        // Simultaneous read and write: write first, read stalled then issued once
        bus.mem_data_cmd_v_i = 1'b1; bus.mem_data_cmd_addr_i = 40'h80000010;
        bus.mem_data_cmd_payload_i = 10'h3C1; bus.mem_data_cmd_size_i = 2'd3;
        bus.mem_data_cmd_data_i = 64'h0123456789ABCDEF;
        bus.mem_cmd_v_i = 1'b1; bus.mem_cmd_addr_i = 40'h8000010C;
        bus.mem_cmd_payload_i = 10'h0F0; bus.mem_cmd_size_i = 2'd2; bus.mem_cmd_nc_i = 1'b0;
        @(negedge clk);
        check("arb_rrdy", 64'(bus.mem_cmd_ready_o),      64'(1'b0));
        check("arb_wrdy", 64'(bus.mem_data_cmd_ready_o), 64'(1'b1));
        @(posedge clk); #1;
        bus.mem_data_cmd_v_i = 1'b0;
        cur_exp = model(1'b1, 40'h80000010, 10'h3C1, 2'd3, 1'b1, 64'h0123456789ABCDEF);
        sb_q.push_back(cur_exp);
        l15_complete(1, 1, 1'b0);
        @(posedge clk); #1;
        bus.mem_cmd_v_i = 1'b0;
        cur_exp = model(1'b0, 40'h8000010C, 10'h0F0, 2'd2, 1'b0, 64'd0);
        sb_q.push_back(cur_exp);
        l15_complete(0, 0, 1'b0);

        // Ack withheld 10 cycles with a spurious response during REQ
        issue(1'b0, 40'h80000044, 10'h155, 2'd2, 1'b1, 64'd0, ok);
        if (ok) l15_complete(10, 1, 1'b1);

        // Misaligned 4B store, then a legal read
        issue(1'b1, 40'h80000006, 10'h001, 2'd2, 1'b1, 64'hCAFEF00D, ok);
        repeat (3) begin
            @(negedge clk);
            check("err_sticky", 64'(bus.protocol_error_o),   64'(exp_err));
            check("err_noval",  64'(bus.transducer_l15_val), 64'(1'b0));
        end
        @(posedge clk); #1;
        issue(1'b0, 40'h80000100, 10'h2B, 2'd0, 1'b1, 64'd0, ok);
        if (ok) l15_complete(1, 0, 1'b0);

        // Reset while waiting for the response
        issue(1'b0, 40'h80002000, 10'h2AA, 2'd3, 1'b1, 64'd0, ok);
        bus.l15_transducer_ack = 1'b1;
        @(posedge clk); #1;
        bus.l15_transducer_ack = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        exp_err = 1'b0;
        check("mid_rst_val",  64'(bus.transducer_l15_val),     64'(1'b0));
        check("mid_rst_wrdy", 64'(bus.mem_data_cmd_ready_o),   64'(1'b0));
        check("mid_rst_rrdy", 64'(bus.mem_cmd_ready_o),        64'(1'b0));
        check("mid_rst_addr", 64'(bus.transducer_l15_address), 64'(0));
        check("mid_rst_pay",  64'(bus.mem_payload_o),          64'(0));
        check("mid_rst_sz",   64'(bus.nc_size_o),              64'(0));
        check("mid_rst_err",  64'(bus.protocol_error_o),       64'(exp_err));
        bus.l15_transducer_val = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus.l15_transducer_val = 1'b0;
        bus.l15_transducer_ack = 1'b1;
        @(negedge clk);
        check("late_val",     64'(bus.transducer_l15_val),     64'(1'b0));
        check("late_req_ack", 64'(bus.transducer_l15_req_ack), 64'(1'b0));
        check("late_wrdy",    64'(bus.mem_data_cmd_ready_o),   64'(1'b1));
        @(posedge clk); #1;
        bus.l15_transducer_ack = 1'b0;
        issue(1'b1, 40'h80003008, 10'h077, 2'd3, 1'b1, 64'hA5A5_5A5A_1234_5678, ok);
        if (ok) l15_complete(0, 2, 1'b0);

        // Randomized commands
        for (int t = 0; t < 40; t++) begin
            is_wr = 1'($urandom_range(0, 1));
            nc    = 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 3));
            p     = 10'($urandom);
            d     = {$urandom, $urandom};
            a     = {8'h80, $urandom};
            n     = 1 << sz;
            if (is_wr && $urandom_range(0, 4) != 0) a = (a / 40'(n)) * 40'(n);
            issue(is_wr, a, p, sz, nc, d, ok);
            if (ok) l15_complete(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                                 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
